mips_mem_arbiter: RTL and testbench
===================================

// Module: mips_mem_arbiter
// PURPOSE
//  Shares the single unified MIPS32 instruction/data memory between three requesters:
//  host loader (port 0), data access for LW/SW (port 1), and instruction fetch (port 2).
//  One access is outstanding at a time. The arbiter sequences each access as ISSUE then
//  RESP and returns read data with a one-hot response strobe.
//  Sits between the pipeline stages and the synchronous-read memory macro.
// PARAMETERS
//  AW            5   word-address width (2**AW words)
//  DW            32  data width
//  STARVE_LIMIT  4   consecutive arbitration losses after which a waiting port is forced to win
// PORTS
//  clk          in   1    single clock, rising edge
//  rst_n        in   1    reset, asynchronous, active-low
//  cpu_halted   in   1    1 = pipeline halted; raises host priority
//  req          in   3    per-port request; port holds req/addr/wdata/we until its gnt
//  host_addr    in   AW   host word address
//  host_wdata   in   DW   host write data
//  host_we      in   1    host write enable (0 = read)
//  data_addr    in   AW   LW/SW word address
//  data_wdata   in   DW   SW data
//  data_we      in   1    1 = SW, 0 = LW
//  if_addr      in   AW   fetch address (read only)
//  gnt          out  3    one-hot, 1-cycle pulse in the ISSUE cycle
//  rsp_valid    out  3    one-hot, 1-cycle pulse; read data or write ack
//  rsp_data     out  DW   read data, valid with rsp_valid; 0 for write acks
//  mem_en       out  1    memory access strobe
//  mem_we       out  1    memory write
//  mem_addr     out  AW   memory address
//  mem_wdata    out  DW   memory write data
//  mem_rdata    in   DW   memory read data, valid one cycle after mem_en
//  stat_sel     in   2    statistics select: 0/1/2 = grants of port 0/1/2, 3 = conflict cycles
//  stat_val     out  32   selected statistic
// BEHAVIOUR
//  Reset: state=IDLE. gnt, rsp_valid, rsp_data, mem_* and all counters are 0.
//   Reset mid-access aborts the access with no rsp_valid. A write in ISSUE is not guaranteed.
//  FSM states:
//   IDLE -> ISSUE when any req is set.
//   ISSUE -> RESP, always.
//   RESP -> ISSUE if any req (other than the one just served) is pending, else IDLE.
//  ISSUE cycle: the winner's gnt=1 and mem_en=1. mem_we/addr/wdata come from the winner's
//   inputs, which are latched at the arbitration edge. Fetch always has mem_we=0.
//  RESP cycle: mem_rdata is captured at the end of the cycle.
//   The next cycle has rsp_valid[winner]=1 and rsp_data=mem_rdata (reads) or 0 (writes).
//  Latency: req is seen at edge E0, gnt and mem_en are high during E0..E1, and rsp_valid
//   is high during E2..E3. Peak throughput is 1 access per 2 cycles.
//  The served port must drop req in the cycle after its gnt, or it is treated as a new request.
//  Priority, evaluated at each arbitration edge:
//   1. Starved ports first (wait count >= STARVE_LIMIT); ties go to the lowest port index.
//   2. Otherwise, if cpu_halted=1, the order is host > data > fetch.
//   3. Otherwise, the order is data > fetch > host.
//  Wait counters: a requesting port that loses increments its counter, saturating at
//   STARVE_LIMIT. The counter clears on grant or when req drops.
//  Conflict cycle: an arbitration edge with 2 or more requests set.
//  Address: no range check. mem_addr is exactly AW bits and wraps implicitly.
//  No combinational path from req to gnt. All outputs are registered.
// CONFIGURATION
//  MIPS_ARB_STATS_EN defined: four 32-bit saturating counters are built: grants per port and
//   conflict cycles. They clear on reset only. stat_val returns the counter chosen by stat_sel.
//  MIPS_ARB_STATS_EN undefined: no counters are built and stat_val is constant 0.
//   All other behaviour is identical.
// TESTING
//  1. Single fetch: req=3'b100, if_addr=5, mem word 5=0xDEADBEEF.
//     -> gnt=100 at +1 cycle; rsp_valid=100 and rsp_data=0xDEADBEEF at +3.
//  2. Data vs fetch collide: req=110, data_we=1, data_addr=7, data_wdata=0x55, cpu_halted=0.
//     -> data is granted first and word 7 becomes 0x55. Fetch is granted 2 cycles later.
//  3. Starvation: data req held continuously with fetch pending, STARVE_LIMIT=4.
//     -> fetch wins on the 5th arbitration; its wait counter resets.
//  4. Halted load: cpu_halted=1, req=111, host write addr 0 = 0x12345678.
//     -> host is granted first; a later read of addr 0 returns 0x12345678.
//  5. Reset mid-access: drop rst_n during RESP.
//     -> gnt, rsp_valid and mem_en are 0 immediately; no response after release;
//     the next req is served normally.
//  6. Statistics (MIPS_ARB_STATS_EN): run scenario 2, stat_sel=3 -> stat_val=1;
//     stat_sel=1 -> 1. Without the macro -> 0.

Source files
------------

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one synchronous-read MIPS32 memory between the host loader
// (port 0), LW/SW data access (port 1) and instruction fetch (port 2).
// Each access runs ISSUE then RESP. Only one access is outstanding at a time.
// Optional statistics counters are built when MIPS_ARB_STATS_EN is defined.
module mips_mem_arbiter #(
    parameter int unsigned AW           = 5,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_halted,
    input  logic [2:0]    req,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_we,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    input  logic          data_we,
    input  logic [AW-1:0] if_addr,
    output logic [2:0]    gnt,
    output logic [2:0]    rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic [1:0]    stat_sel,
    output logic [31:0]   stat_val
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] Limit = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e state_q, state_d;

    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    // Port being served and whether its access was a write (write acks return 0).
    logic [2:0]    served_q, served_d;
    logic          served_we_q, served_we_d;

    logic [2:0][CW-1:0] wait_q, wait_d;

    logic [2:0] starved;
    logic [2:0] win;
    logic       grant;

    // Starvation flags: a requesting port whose wait count reached the limit.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            starved[i] = req[i] && (wait_q[i] >= Limit);
        end
    end

    // Priority pick: starved ports by index, else halted order, else running order.
    always_comb begin
        win = 3'b000;
        if (|starved) begin
            if (starved[0])      win = 3'b001;
            else if (starved[1]) win = 3'b010;
            else                 win = 3'b100;
        end else if (cpu_halted) begin
            if (req[0])      win = 3'b001;
            else if (req[1]) win = 3'b010;
            else if (req[2]) win = 3'b100;
        end else begin
            if (req[1])      win = 3'b010;
            else if (req[2]) win = 3'b100;
            else if (req[0]) win = 3'b001;
        end
    end

    // Next-state and registered-output logic for the ISSUE/RESP sequence.
    always_comb begin
        state_d     = state_q;
        gnt_d       = 3'b000;
        rsp_valid_d = 3'b000;
        rsp_data_d  = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        served_d    = served_q;
        served_we_d = served_we_q;
        grant       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StIssue;
                    grant   = 1'b1;
                end
            end
            StIssue: begin
                state_d = StResp;
            end
            StResp: begin
                // mem_rdata is valid now, one cycle after the ISSUE strobe.
                rsp_valid_d = served_q;
                rsp_data_d  = served_we_q ? '0 : mem_rdata;
                if (|req) begin
                    state_d = StIssue;
                    grant   = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Latch the winner's request fields at the arbitration edge.
        if (grant) begin
            gnt_d    = win;
            mem_en_d = 1'b1;
            served_d = win;
            unique case (win)
                3'b001: begin
                    mem_we_d    = host_we;
                    mem_addr_d  = host_addr;
                    mem_wdata_d = host_wdata;
                end
                3'b010: begin
                    mem_we_d    = data_we;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                end
                3'b100: begin
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
                default: begin
                    mem_we_d = 1'b0;
                end
            endcase
            served_we_d = mem_we_d;
        end
    end

    // Wait counters: count losses while requesting, saturate, clear on grant or req drop.
    always_comb begin
        wait_d = wait_q;
        for (int i = 0; i < 3; i++) begin
            if (!req[i]) begin
                wait_d[i] = '0;
            end else if (grant) begin
                if (win[i]) begin
                    wait_d[i] = '0;
                end else if (wait_q[i] < Limit) begin
                    wait_d[i] = wait_q[i] + 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_q       <= 3'b000;
            rsp_valid_q <= 3'b000;
            rsp_data_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            served_q    <= 3'b000;
            served_we_q <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            served_q    <= served_d;
            served_we_q <= served_we_d;
            wait_q      <= wait_d;
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MIPS_ARB_STATS_EN
    // Index 0..2: grants per port, index 3: conflict cycles.
    logic [3:0][31:0] stat_q;
    logic [31:0]      stat_val_q;
    logic             conflict;

    // A conflict is an arbitration edge with two or more requests set.
    always_comb begin
        conflict = grant && ($countones(req) >= 2);
    end

    // Saturating statistics counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (grant && win[i] && (stat_q[i] != 32'hFFFF_FFFF)) begin
                    stat_q[i] <= stat_q[i] + 32'd1;
                end
            end
            if (conflict && (stat_q[3] != 32'hFFFF_FFFF)) begin
                stat_q[3] <= stat_q[3] + 32'd1;
            end
        end
    end

    // Registered statistics readout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_val_q <= '0;
        end else begin
            stat_val_q <= stat_q[stat_sel];
        end
    end

    assign stat_val = stat_val_q;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_val        = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a synchronous-read memory model.
module tb_mips_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          cpu_halted;
    logic [2:0]    req;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_we;
    logic [AW-1:0] if_addr;
    logic [2:0]    gnt;
    logic [2:0]    rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    stat_sel;
    logic [31:0]   stat_val;

    logic [DW-1:0] mem [32];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [31:0] exp_conf;
    logic [31:0] exp_g1;
    logic [31:0] exp_g2;

    mips_mem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_halted (cpu_halted),
        .req        (req),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_we    (host_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_we    (data_we),
        .if_addr    (if_addr),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .stat_sel   (stat_sel),
        .stat_val   (stat_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory; pre_we is a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        cpu_halted = 1'b0;
        req        = 3'b000;
        host_addr  = '0;
        host_wdata = '0;
        host_we    = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        data_we    = 1'b0;
        if_addr    = '0;
        stat_sel   = 2'd0;
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_data   = '0;
`ifdef MIPS_ARB_STATS_EN
        exp_conf = 32'd1;
        exp_g1   = 32'd1;
        exp_g2   = 32'd2;
`else
        exp_conf = 32'd0;
        exp_g1   = 32'd0;
        exp_g2   = 32'd0;
`endif

        preload(5'd5, 32'hDEAD_BEEF);
        preload(5'd3, 32'h3333_3333);
        preload(5'd9, 32'h9999_9999);
        preload(5'd4, 32'h4444_4444);
        tick();

        // Reset state
        check("rst_gnt", {29'd0, gnt}, 32'd0);
        check("rst_rsp_valid", {29'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        check("rst_stat_val", stat_val, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1. Single fetch of word 5
        if_addr = 5'd5;
        req     = 3'b100;
        tick();
        check("s1_gnt", {29'd0, gnt}, 32'h4);
        check("s1_mem_en", {31'd0, mem_en}, 32'd1);
        check("s1_mem_addr", {27'd0, mem_addr}, 32'd5);
        check("s1_mem_we", {31'd0, mem_we}, 32'd0);
        req = 3'b000;
        tick();
        check("s1_gnt_drop", {29'd0, gnt}, 32'd0);
        check("s1_mem_en_drop", {31'd0, mem_en}, 32'd0);
        tick();
        check("s1_rsp_valid", {29'd0, rsp_valid}, 32'h4);
        check("s1_rsp_data", rsp_data, 32'hDEAD_BEEF);
        tick();
        check("s1_rsp_valid_drop", {29'd0, rsp_valid}, 32'd0);

        // 2. Data SW collides with fetch, data wins
        data_we    = 1'b1;
        data_addr  = 5'd7;
        data_wdata = 32'h55;
        if_addr    = 5'd3;
        req        = 3'b110;
        tick();
        check("s2_gnt_data", {29'd0, gnt}, 32'h2);
        check("s2_mem_we", {31'd0, mem_we}, 32'd1);
        check("s2_mem_addr", {27'd0, mem_addr}, 32'd7);
        check("s2_mem_wdata", mem_wdata, 32'h55);
        req = 3'b100;
        tick();
        tick();
        check("s2_rsp_valid_data", {29'd0, rsp_valid}, 32'h2);
        check("s2_rsp_data_wack", rsp_data, 32'd0);
        check("s2_gnt_fetch", {29'd0, gnt}, 32'h4);
        check("s2_fetch_addr", {27'd0, mem_addr}, 32'd3);
        check("s2_fetch_we", {31'd0, mem_we}, 32'd0);
        check("s2_word7", mem[7], 32'h55);
        req = 3'b000;
        tick();
        tick();
        check("s2_rsp_valid_fetch", {29'd0, rsp_valid}, 32'h4);
        check("s2_rsp_data_fetch", rsp_data, 32'h3333_3333);
        tick();

        // 6. Statistics after scenarios 1 and 2
        stat_sel = 2'd3;
        tick();
        check("stat_conflict", stat_val, exp_conf);
        stat_sel = 2'd1;
        tick();
        check("stat_grant1", stat_val, exp_g1);
        stat_sel = 2'd2;
        tick();
        check("stat_grant2", stat_val, exp_g2);

        // 3. Starvation: data held continuously, fetch pending
        data_we   = 1'b0;
        data_addr = 5'd1;
        if_addr   = 5'd2;
        req       = 3'b110;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("s3_gnt_data", {29'd0, gnt}, 32'h2);
            tick();
        end
        tick();
        check("s3_starve_win", {29'd0, gnt}, 32'h4);
        tick();
        tick();
        check("s3_wait_cleared", {29'd0, gnt}, 32'h2);
        req = 3'b000;
        tick();
        tick();
        tick();

        // 4. Halted load: host first, then data, then fetch
        cpu_halted = 1'b1;
        host_we    = 1'b1;
        host_addr  = 5'd0;
        host_wdata = 32'h1234_5678;
        data_we    = 1'b0;
        data_addr  = 5'd9;
        if_addr    = 5'd4;
        req        = 3'b111;
        tick();
        check("s4_gnt_host", {29'd0, gnt}, 32'h1);
        check("s4_host_we", {31'd0, mem_we}, 32'd1);
        check("s4_host_addr", {27'd0, mem_addr}, 32'd0);
        req = 3'b110;
        tick();
        tick();
        check("s4_gnt_data", {29'd0, gnt}, 32'h2);
        check("s4_rsp_host", {29'd0, rsp_valid}, 32'h1);
        check("s4_rsp_host_data", rsp_data, 32'd0);
        req = 3'b100;
        tick();
        tick();
        check("s4_gnt_fetch", {29'd0, gnt}, 32'h4);
        check("s4_rsp_data_port", {29'd0, rsp_valid}, 32'h2);
        check("s4_rsp_data_val", rsp_data, 32'h9999_9999);
        req = 3'b000;
        tick();
        tick();
        check("s4_rsp_fetch", {29'd0, rsp_valid}, 32'h4);
        check("s4_rsp_fetch_val", rsp_data, 32'h4444_4444);
        tick();
        host_we = 1'b0;
        req     = 3'b001;
        tick();
        check("s4_gnt_host_rd", {29'd0, gnt}, 32'h1);
        req = 3'b000;
        tick();
        tick();
        check("s4_rsp_host_rd", {29'd0, rsp_valid}, 32'h1);
        check("s4_readback", rsp_data, 32'h1234_5678);
        tick();
        cpu_halted = 1'b0;

        // 5. Reset during RESP
        if_addr = 5'd5;
        req     = 3'b100;
        tick();
        check("s5_gnt", {29'd0, gnt}, 32'h4);
        req = 3'b000;
        tick();
        rst_n = 1'b0;
        #1;
        check("s5_rst_gnt", {29'd0, gnt}, 32'd0);
        check("s5_rst_rsp_valid", {29'd0, rsp_valid}, 32'd0);
        check("s5_rst_mem_en", {31'd0, mem_en}, 32'd0);
        tick();
        rst_n = 1'b1;
        check("s5_no_rsp_a", {29'd0, rsp_valid}, 32'd0);
        tick();
        check("s5_no_rsp_b", {29'd0, rsp_valid}, 32'd0);
        check("s5_stat_cleared", stat_val, 32'd0);
        tick();
        check("s5_no_rsp_c", {29'd0, rsp_valid}, 32'd0);
        data_we   = 1'b0;
        data_addr = 5'd7;
        req       = 3'b010;
        tick();
        check("s5_gnt_after", {29'd0, gnt}, 32'h2);
        req = 3'b000;
        tick();
        tick();
        check("s5_rsp_after", {29'd0, rsp_valid}, 32'h2);
        check("s5_rsp_data_after", rsp_data, 32'h55);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
